// File: rtl/vpu_pkg.sv
// Shared definitions for the VPU ALU issue sequencer: op codes, lane geometry, FSM states.
// VPU_ISSUE_MUL_EN adds the MULSTEP state and makes op 11 (MUL) legal.
package vpu_pkg;

  localparam int VLANES = 8;
  localparam int ELEN   = 16;

  localparam logic [3:0] OP_PASS = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_MAX  = 4'd6;
  localparam logic [3:0] OP_MIN  = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;

  // bit positions inside the one-hot select vector
  localparam int SEL_ADD = 0;
  localparam int SEL_SUB = 1;
  localparam int SEL_AND = 2;
  localparam int SEL_OR  = 3;
  localparam int SEL_XOR = 4;
  localparam int SEL_MAX = 5;
  localparam int SEL_MIN = 6;
  localparam int SEL_SLL = 7;
  localparam int SEL_SRL = 8;
  localparam int SEL_SRA = 9;

`ifdef VPU_ISSUE_MUL_EN
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_MULSTEP = 2'd2,
    ST_DONE    = 2'd3
  } vpu_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd3
  } vpu_state_e;
`endif

  function automatic logic op_legal(input logic [3:0] op);
`ifdef VPU_ISSUE_MUL_EN
    return (op <= OP_MUL);
`else
    return (op <= OP_SRA);
`endif
  endfunction

  // PASS and MUL carry no direct select; MUL is sequenced through the adder
  function automatic logic [9:0] op_sel(input logic [3:0] op);
    logic [9:0] s;
    s = '0;
    case (op)
      OP_ADD:  s[SEL_ADD] = 1'b1;
      OP_SUB:  s[SEL_SUB] = 1'b1;
      OP_AND:  s[SEL_AND] = 1'b1;
      OP_OR:   s[SEL_OR]  = 1'b1;
      OP_XOR:  s[SEL_XOR] = 1'b1;
      OP_MAX:  s[SEL_MAX] = 1'b1;
      OP_MIN:  s[SEL_MIN] = 1'b1;
      OP_SLL:  s[SEL_SLL] = 1'b1;
      OP_SRL:  s[SEL_SRL] = 1'b1;
      OP_SRA:  s[SEL_SRA] = 1'b1;
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/vpu_mul_seq.sv
// Shift-and-add multiply sequencer: one partial product per step through the shared ALU adder.
// Only instantiated when VPU_ISSUE_MUL_EN is defined.
module vpu_mul_seq
  import vpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_start,
  input  logic            i_step,
  input  logic [ELEN-1:0] i_a,
  input  logic [ELEN-1:0] i_b,
  input  logic [ELEN-1:0] i_sum,
  output logic [ELEN-1:0] o_acc,
  output logic [ELEN-1:0] o_addend,
  output logic            o_last
);

  logic [ELEN-1:0] r_a;
  logic [ELEN-1:0] r_b;
  logic [ELEN-1:0] r_acc;
  logic [3:0]      r_step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_acc  <= '0;
      r_step <= '0;
    end else if (i_start) begin
      // start wins over step so the last step of one element can load the next
      r_a    <= i_a;
      r_b    <= i_b;
      r_acc  <= '0;
      r_step <= '0;
    end else if (i_step) begin
      r_acc  <= i_sum;
      r_step <= r_step + 4'd1;
    end
  end

  assign o_acc    = r_acc;
  assign o_addend = r_b[r_step] ? (r_a << r_step) : '0;
  assign o_last   = (r_step == 4'd15);

endmodule

// File: rtl/vpu_alu_issue.sv
// Issues vector requests one 16-bit element per cycle to an external combinational ALU.
// Define VPU_ISSUE_MUL_EN to enable MUL (op 11) via the vpu_mul_seq shift-and-add sequencer.
//
// state   | meaning
// IDLE    | req_ready high, waiting for a request
// ISSUE   | drive element r_elem to the ALU, store result into its lane
// MULSTEP | one of 16 shift-and-add steps of a MUL element (MUL build only)
// DONE    | rsp_valid high, response held until rsp_ready
module vpu_alu_issue
  import vpu_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [3:0]             req_op,
  input  logic [2:0]             req_vlen,
  input  logic [VLANES*ELEN-1:0] req_vs1,
  input  logic [VLANES*ELEN-1:0] req_vs2,
  input  logic                   req_bcast,
  output logic                   alu_enable,
  output logic                   alu_addsel,
  output logic                   alu_subsel,
  output logic                   alu_andsel,
  output logic                   alu_orsel,
  output logic                   alu_xorsel,
  output logic                   alu_maxsel,
  output logic                   alu_minsel,
  output logic                   alu_sllsel,
  output logic                   alu_srlsel,
  output logic                   alu_srasel,
  output logic [ELEN-1:0]        alu_ds1,
  output logic [ELEN-1:0]        alu_ds2,
  input  logic [ELEN-1:0]        alu_rd,
  input  logic                   alu_gt,
  input  logic                   alu_eq,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [VLANES*ELEN-1:0] rsp_vd,
  output logic [VLANES-1:0]      rsp_gt,
  output logic [VLANES-1:0]      rsp_eq,
  output logic                   rsp_err
);

  vpu_state_e r_state, w_state_nxt;
  logic                   r_live;
  logic [3:0]             r_op;
  logic [2:0]             r_vlen;
  logic [2:0]             r_elem;
  logic [VLANES*ELEN-1:0] r_vs1;
  logic [VLANES*ELEN-1:0] r_vs2;
  logic                   r_bcast;
  logic [VLANES*ELEN-1:0] r_vd;
  logic [VLANES-1:0]      r_gt;
  logic [VLANES-1:0]      r_eq;
  logic                   r_err;

  logic [9:0]      w_sel;
  logic            w_accept;
  logic            w_last;
  logic            w_store;
  logic [ELEN-1:0] w_st_rd;
  logic            w_st_gt;
  logic            w_st_eq;
  logic [ELEN-1:0] w_ds1_e;
  logic [ELEN-1:0] w_ds2_e;

  // req_ready stays low through reset and rises on the first clock after release
  assign req_ready = r_live && (r_state == ST_IDLE);
  assign w_accept  = req_valid && req_ready;
  assign w_last    = (r_elem == r_vlen);
  assign w_ds1_e   = r_vs1[{r_elem, 4'b0000} +: ELEN];
  assign w_ds2_e   = r_bcast ? r_vs2[ELEN-1:0] : r_vs2[{r_elem, 4'b0000} +: ELEN];

`ifdef VPU_ISSUE_MUL_EN
  logic            w_mul_start;
  logic            w_mul_step;
  logic            w_mul_last;
  logic [2:0]      w_ld_elem;
  logic [ELEN-1:0] w_mul_a;
  logic [ELEN-1:0] w_mul_b;
  logic [ELEN-1:0] w_mul_acc;
  logic [ELEN-1:0] w_mul_addend;

  // from MULSTEP the sequencer reloads with the element after the one being finished
  assign w_ld_elem = (r_state == ST_ISSUE) ? r_elem : (r_elem + 3'd1);
  assign w_mul_a   = r_vs1[{w_ld_elem, 4'b0000} +: ELEN];
  assign w_mul_b   = r_bcast ? r_vs2[ELEN-1:0] : r_vs2[{w_ld_elem, 4'b0000} +: ELEN];

  vpu_mul_seq u_mul_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (w_mul_start),
    .i_step   (w_mul_step),
    .i_a      (w_mul_a),
    .i_b      (w_mul_b),
    .i_sum    (alu_rd),
    .o_acc    (w_mul_acc),
    .o_addend (w_mul_addend),
    .o_last   (w_mul_last)
  );
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_sel       = '0;
    alu_enable  = 1'b0;
    alu_ds1     = '0;
    alu_ds2     = '0;
    w_store     = 1'b0;
    w_st_rd     = alu_rd;
    w_st_gt     = alu_gt;
    w_st_eq     = alu_eq;
`ifdef VPU_ISSUE_MUL_EN
    w_mul_start = 1'b0;
    w_mul_step  = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_nxt = op_legal(req_op) ? ST_ISSUE : ST_DONE;
      end
      ST_ISSUE: begin
`ifdef VPU_ISSUE_MUL_EN
        // MUL spends its ISSUE cycle loading element 0 into the sequencer
        if (r_op == OP_MUL) begin
          alu_enable     = 1'b1;
          w_sel[SEL_ADD] = 1'b1;
          w_mul_start    = 1'b1;
          w_state_nxt    = ST_MULSTEP;
        end else
`endif
        begin
          alu_enable = (r_op != OP_PASS);
          w_sel      = op_sel(r_op);
          alu_ds1    = w_ds1_e;
          alu_ds2    = w_ds2_e;
          w_store    = 1'b1;
          if (w_last) w_state_nxt = ST_DONE;
        end
      end
`ifdef VPU_ISSUE_MUL_EN
      ST_MULSTEP: begin
        alu_enable     = 1'b1;
        w_sel[SEL_ADD] = 1'b1;
        alu_ds1        = w_mul_acc;
        alu_ds2        = w_mul_addend;
        w_mul_step     = 1'b1;
        if (w_mul_last) begin
          w_store = 1'b1;
          w_st_gt = 1'b0;
          w_st_eq = 1'b0;
          if (w_last) w_state_nxt = ST_DONE;
          else        w_mul_start = 1'b1;
        end
      end
`endif
      ST_DONE: begin
        if (rsp_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign alu_addsel = w_sel[SEL_ADD];
  assign alu_subsel = w_sel[SEL_SUB];
  assign alu_andsel = w_sel[SEL_AND];
  assign alu_orsel  = w_sel[SEL_OR];
  assign alu_xorsel = w_sel[SEL_XOR];
  assign alu_maxsel = w_sel[SEL_MAX];
  assign alu_minsel = w_sel[SEL_MIN];
  assign alu_sllsel = w_sel[SEL_SLL];
  assign alu_srlsel = w_sel[SEL_SRL];
  assign alu_srasel = w_sel[SEL_SRA];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_live  <= 1'b0;
      r_op    <= '0;
      r_vlen  <= '0;
      r_elem  <= '0;
      r_vs1   <= '0;
      r_vs2   <= '0;
      r_bcast <= 1'b0;
      r_vd    <= '0;
      r_gt    <= '0;
      r_eq    <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_live  <= 1'b1;
      if (w_accept) begin
        // lanes above vlen, and every lane of an illegal op, stay zero
        r_op    <= req_op;
        r_vlen  <= req_vlen;
        r_vs1   <= req_vs1;
        r_vs2   <= req_vs2;
        r_bcast <= req_bcast;
        r_elem  <= '0;
        r_vd    <= '0;
        r_gt    <= '0;
        r_eq    <= '0;
        r_err   <= ~op_legal(req_op);
      end else if (w_store) begin
        r_vd[{r_elem, 4'b0000} +: ELEN] <= w_st_rd;
        r_gt[r_elem]                    <= w_st_gt;
        r_eq[r_elem]                    <= w_st_eq;
        if (!w_last) r_elem <= r_elem + 3'd1;
      end
    end
  end

  assign rsp_valid = (r_state == ST_DONE);
  assign rsp_vd    = r_vd;
  assign rsp_gt    = r_gt;
  assign rsp_eq    = r_eq;
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_vpu_alu_issue.sv
// Scoreboard bench for vpu_alu_issue with a behavioural 16-bit ALU; follows VPU_ISSUE_MUL_EN if defined.
module tb_vpu_alu_issue;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [3:0]   req_op = '0;
  logic [2:0]   req_vlen = '0;
  logic [127:0] req_vs1 = '0;
  logic [127:0] req_vs2 = '0;
  logic         req_bcast = 1'b0;
  logic         alu_enable, alu_addsel, alu_subsel, alu_andsel, alu_orsel, alu_xorsel;
  logic         alu_maxsel, alu_minsel, alu_sllsel, alu_srlsel, alu_srasel;
  logic [15:0]  alu_ds1, alu_ds2, alu_rd;
  logic         alu_gt, alu_eq;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic [127:0] rsp_vd;
  logic [7:0]   rsp_gt, rsp_eq;
  logic         rsp_err;

  vpu_alu_issue dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_vlen(req_vlen),
    .req_vs1(req_vs1), .req_vs2(req_vs2), .req_bcast(req_bcast),
    .alu_enable(alu_enable), .alu_addsel(alu_addsel), .alu_subsel(alu_subsel),
    .alu_andsel(alu_andsel), .alu_orsel(alu_orsel), .alu_xorsel(alu_xorsel),
    .alu_maxsel(alu_maxsel), .alu_minsel(alu_minsel), .alu_sllsel(alu_sllsel),
    .alu_srlsel(alu_srlsel), .alu_srasel(alu_srasel),
    .alu_ds1(alu_ds1), .alu_ds2(alu_ds2), .alu_rd(alu_rd), .alu_gt(alu_gt), .alu_eq(alu_eq),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_vd(rsp_vd),
    .rsp_gt(rsp_gt), .rsp_eq(rsp_eq), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  logic [9:0] sels;
  assign sels = {alu_srasel, alu_srlsel, alu_sllsel, alu_minsel, alu_maxsel,
                 alu_xorsel, alu_orsel, alu_andsel, alu_subsel, alu_addsel};

  // external ALU: disabled means pass-through of ds1; flags are signed compares
  always_comb begin
    alu_rd = '0;
    if (!alu_enable)     alu_rd = alu_ds1;
    else if (alu_addsel) alu_rd = alu_ds1 + alu_ds2;
    else if (alu_subsel) alu_rd = alu_ds1 - alu_ds2;
    else if (alu_andsel) alu_rd = alu_ds1 & alu_ds2;
    else if (alu_orsel)  alu_rd = alu_ds1 | alu_ds2;
    else if (alu_xorsel) alu_rd = alu_ds1 ^ alu_ds2;
    else if (alu_maxsel) alu_rd = ($signed(alu_ds1) > $signed(alu_ds2)) ? alu_ds1 : alu_ds2;
    else if (alu_minsel) alu_rd = ($signed(alu_ds1) < $signed(alu_ds2)) ? alu_ds1 : alu_ds2;
    else if (alu_sllsel) alu_rd = alu_ds1 << alu_ds2[3:0];
    else if (alu_srlsel) alu_rd = alu_ds1 >> alu_ds2[3:0];
    else if (alu_srasel) alu_rd = $signed(alu_ds1) >>> alu_ds2[3:0];
    alu_gt = $signed(alu_ds1) > $signed(alu_ds2);
    alu_eq = (alu_ds1 == alu_ds2);
  end

  typedef struct {
    logic [127:0] vd;
    logic [7:0]   gt;
    logic [7:0]   eq;
    logic         err;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  bit   prev_rv = 1'b0;
  bit   no_sel_win = 1'b0;
  logic [127:0] s_vd;
  logic [7:0]   s_gt, s_eq;
  logic         s_err;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] pack8(input logic [15:0] l0, l1, l2, l3, l4, l5, l6, l7);
    return {l7, l6, l5, l4, l3, l2, l1, l0};
  endfunction

  always @(posedge clk) cyc++;

  // monitor: latency, hold stability and scoreboard pop on each completed response
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_rv = 1'b0;
    end else begin
      if (req_valid && req_ready) acc_cyc = cyc;
      if (no_sel_win) check("no_alu_select", {alu_enable, sels}, 11'd0);
      if (rsp_valid) begin
        if (!prev_rv) begin
          s_vd = rsp_vd; s_gt = rsp_gt; s_eq = rsp_eq; s_err = rsp_err;
          if (sb.size() > 0) check("latency", cyc - acc_cyc, sb[0].lat);
        end else begin
          check("hold_stable", {rsp_vd, rsp_gt, rsp_eq, rsp_err}, {s_vd, s_gt, s_eq, s_err});
          check("req_ready_in_done", req_ready, 1'b0);
        end
        if (rsp_ready) begin
          if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_rsp: got response vd %0h expected none", rsp_vd);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check("rsp_vd", rsp_vd, e.vd);
            check("rsp_gt", rsp_gt, e.gt);
            check("rsp_eq", rsp_eq, e.eq);
            check("rsp_err", rsp_err, e.err);
          end
        end
      end
      prev_rv = rsp_valid;
    end
  end

  task automatic send(input logic [3:0] op, input logic [2:0] vlen, input logic [127:0] a,
                      input logic [127:0] b, input logic bc, input logic [127:0] evd,
                      input logic [7:0] egt, input logic [7:0] eeq, input logic eerr,
                      input int elat, input bit expect_rsp);
    int t;
    exp_t e;
    if (expect_rsp) begin
      e.vd = evd; e.gt = egt; e.eq = eeq; e.err = eerr; e.lat = elat;
      sb.push_back(e);
    end
    req_op = op; req_vlen = vlen; req_vs1 = a; req_vs2 = b; req_bcast = bc;
    req_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!req_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: got req_ready 0 expected 1");
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || !req_ready) && t < 400) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 400) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req_ready"}, req_ready, 1'b0);
    check({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    check({tag, "_rsp"}, {rsp_vd, rsp_gt, rsp_eq, rsp_err}, '0);
    check({tag, "_alu"}, {alu_enable, sels, alu_ds1, alu_ds2}, '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    #3 check_reset_vals("reset");
    #20 rst_n = 1'b1;
    @(posedge clk); #1;

    // ADD vlen=3, lanes above 3 must come back zero
    send(4'd1, 3'd3, pack8(16'h1, 16'h2, 16'h3, 16'h7FFF, 16'h1234, 16'h1234, 16'h1234, 16'h1234),
         pack8(16'h1, 16'h1, 16'h1, 16'h1, 16'h1, 16'h1, 16'h1, 16'h1), 1'b0,
         pack8(16'h2, 16'h3, 16'h4, 16'h8000, 16'h0, 16'h0, 16'h0, 16'h0),
         8'b0000_1110, 8'b0000_0001, 1'b0, 5, 1'b1);
    drain();

    // MAX with broadcast of vs2 lane 0
    send(4'd6, 3'd1, pack8(16'hFFFF, 16'h5, 16'h9, 16'h9, 16'h9, 16'h9, 16'h9, 16'h9),
         pack8(16'h3, 16'h0100, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0), 1'b1,
         pack8(16'h3, 16'h5, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0),
         8'b0000_0010, 8'b0000_0000, 1'b0, 3, 1'b1);
    drain();

    // SUB over all 8 lanes with rsp_ready withheld for 10 cycles
    rsp_ready = 1'b0;
    send(4'd2, 3'd7, pack8(16'h10, 16'h20, 16'h30, 16'h40, 16'h50, 16'h60, 16'h70, 16'h80),
         pack8(16'h1, 16'h2, 16'h3, 16'h4, 16'h5, 16'h6, 16'h7, 16'h8), 1'b0,
         pack8(16'h0F, 16'h1E, 16'h2D, 16'h3C, 16'h4B, 16'h5A, 16'h69, 16'h78),
         8'hFF, 8'h00, 1'b0, 9, 1'b1);
    t = 0;
    while (!rsp_valid && t < 100) begin
      @(posedge clk); #1; t++;
    end
    check("sub_rsp_valid_seen", rsp_valid, 1'b1);
    repeat (10) @(posedge clk);
    #1 rsp_ready = 1'b1;
    drain();

    // illegal op 13: error response, ALU never touched
    no_sel_win = 1'b1;
    send(4'd13, 3'd2, pack8(16'h11, 16'h22, 16'h33, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0),
         pack8(16'h1, 16'h1, 16'h1, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0), 1'b0,
         '0, 8'h00, 8'h00, 1'b1, 1, 1'b1);
    drain();
    no_sel_win = 1'b0;

    // MUL 7*9
`ifdef VPU_ISSUE_MUL_EN
    send(4'd11, 3'd0, pack8(16'h7, 16'h5, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0),
         pack8(16'h9, 16'h5, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0), 1'b0,
         pack8(16'd63, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0),
         8'h00, 8'h00, 1'b0, 18, 1'b1);
`else
    send(4'd11, 3'd0, pack8(16'h7, 16'h5, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0),
         pack8(16'h9, 16'h5, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0), 1'b0,
         '0, 8'h00, 8'h00, 1'b1, 1, 1'b1);
`endif
    drain();

    // reset during the second ISSUE cycle: request dropped, no response
    send(4'd1, 3'd7, pack8(16'h1, 16'h1, 16'h1, 16'h1, 16'h1, 16'h1, 16'h1, 16'h1),
         pack8(16'h2, 16'h2, 16'h2, 16'h2, 16'h2, 16'h2, 16'h2, 16'h2), 1'b0,
         '0, 8'h00, 8'h00, 1'b0, 0, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("midrst");
    repeat (2) @(negedge clk);
    check("midrst_req_ready_held", req_ready, 1'b0);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("midrst_no_rsp", rsp_valid, 1'b0);
    end
    @(posedge clk); #1;

    // assorted ops after reset, hand-computed
    send(4'd5, 3'd1, pack8(16'hF0F0, 16'hAAAA, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0),
         pack8(16'h0FF0, 16'h5555, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0), 1'b0,
         pack8(16'hFF00, 16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0),
         8'h00, 8'h00, 1'b0, 3, 1'b1);
    drain();
    send(4'd10, 3'd1, pack8(16'h8000, 16'h0100, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0),
         pack8(16'h4, 16'h2, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0), 1'b0,
         pack8(16'hF800, 16'h0040, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0),
         8'b0000_0010, 8'h00, 1'b0, 3, 1'b1);
    drain();
    send(4'd8, 3'd0, pack8(16'h3, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0),
         pack8(16'h3, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0), 1'b0,
         pack8(16'h0018, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0),
         8'h00, 8'h01, 1'b0, 2, 1'b1);
    drain();
    send(4'd7, 3'd0, pack8(16'h8000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0),
         pack8(16'h0001, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0), 1'b0,
         pack8(16'h8000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0),
         8'h00, 8'h00, 1'b0, 2, 1'b1);
    drain();
    send(4'd3, 3'd0, pack8(16'h0FF0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0),
         pack8(16'h3C3C, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0), 1'b0,
         pack8(16'h0C30, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0),
         8'h00, 8'h00, 1'b0, 2, 1'b1);
    drain();
    send(4'd9, 3'd0, pack8(16'h8000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0),
         pack8(16'h0001, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0), 1'b0,
         pack8(16'h4000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0),
         8'h00, 8'h00, 1'b0, 2, 1'b1);
    drain();
    send(4'd4, 3'd0, pack8(16'h00F0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0),
         pack8(16'h0F00, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0), 1'b0,
         pack8(16'h0FF0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0),
         8'h00, 8'h00, 1'b0, 2, 1'b1);
    drain();
    send(4'd0, 3'd0, pack8(16'h1234, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0),
         pack8(16'h0001, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0), 1'b0,
         pack8(16'h1234, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0),
         8'h01, 8'h00, 1'b0, 2, 1'b1);
    drain();

    repeat (3) @(posedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vpu_alu_issue.md
VPU_ALU_ISSUE -- requirements
Module: vpu_alu_issue

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL have ports: rst_n  in  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have ports: req_valid in 1 / req_ready out 1  request handshake.
REQ-004 SHALL have ports: req_op in 4 (op code, vpu_pkg), req_vlen in 3 (element count minus 1, 1..8), req_vs1 in 128, req_vs2 in 128 (element i = bits 16i+15:16i), req_bcast in 1 (vs2 element 0 to all lanes).
REQ-005 SHALL have ports: alu_enable, alu_addsel, alu_subsel, alu_andsel, alu_orsel, alu_xorsel, alu_maxsel, alu_minsel, alu_sllsel, alu_srlsel, alu_srasel  out 1 each; alu_ds1, alu_ds2  out 16  drive to the 16-bit ALU.
REQ-006 SHALL have ports: alu_rd in 16, alu_gt in 1, alu_eq in 1  combinational ALU results, same cycle.
REQ-007 SHALL have ports: rsp_valid out 1 / rsp_ready in 1, rsp_vd out 128, rsp_gt out 8, rsp_eq out 8, rsp_err out 1.

Function
REQ-008 SHALL implement FSM IDLE, ISSUE, MULSTEP, DONE; req_ready=1 only in IDLE.
REQ-009 SHALL capture op, vlen, vs1, vs2, bcast on req_valid&req_ready and go IDLE->ISSUE (or DONE for illegal op 12..15).
REQ-010 SHALL in ISSUE drive element e: alu_ds1=vs1[e], alu_ds2=vs2[e] (vs2[0] if bcast), exactly one select per op; PASS drives alu_enable=0, all other ops alu_enable=1.
REQ-011 SHALL store alu_rd, alu_gt, alu_eq into lane e at the end of the same cycle; one element per cycle; e increments 0..vlen.
REQ-012 SHALL go ISSUE->DONE after element vlen; non-MUL latency from accept to rsp_valid = vlen+2 cycles.
REQ-013 SHALL in DONE hold rsp_valid=1 and all rsp_* stable until rsp_ready; on rsp_valid&rsp_ready go IDLE; no same-cycle accept of a new request.
REQ-014 SHALL zero rsp_vd/rsp_gt/rsp_eq lanes above vlen.
REQ-015 SHALL for illegal op return rsp_vd=0, flags 0, rsp_err=1; rsp_err=0 otherwise.
REQ-016 SHALL in IDLE/DONE drive all ALU selects 0, alu_enable=0, alu_ds1=alu_ds2=0.
REQ-017 SHALL encode ops: 0 PASS,1 ADD,2 SUB,3 AND,4 OR,5 XOR,6 MAX,7 MIN,8 SLL,9 SRL,10 SRA,11 MUL.

Reset
REQ-018 SHALL on rst_n=0 force FSM=IDLE, element counter=0, req_ready=0 during reset then 1, rsp_valid=0, rsp_vd/rsp_gt/rsp_eq/rsp_err=0, ALU outputs per REQ-016.
REQ-019 SHALL on reset mid-operation discard the in-flight request with no response.

Configuration
REQ-020 SHALL with VPU_ISSUE_MUL_EN defined execute MUL per element in MULSTEP: 16 steps, step i drives alu_addsel, alu_ds1=acc, alu_ds2=(b[i]? a<<i : 0), acc<=alu_rd; lane result = acc (low 16 bits) after step 15; flags 0; element latency 16 cycles.
REQ-021 SHALL without VPU_ISSUE_MUL_EN treat op 11 as illegal (REQ-015); MULSTEP state and accumulator absent.

Structure
REQ-022 SHALL place op-code constants, VLANES=8, ELEN=16 and FSM state typedef in shared package vpu_pkg.
REQ-023 SHALL place the multiply step counter/accumulator in sub-module vpu_mul_seq, instantiated only under VPU_ISSUE_MUL_EN.

Verification
REQ-024 SHALL cover ADD vlen=3 (4 elems), vs1 lanes 1,2,3,0x7FFF, vs2 all 1 -> rsp_vd lanes 2,3,4,0x8000, lanes 4..7=0, rsp_valid 5 cycles after accept.
REQ-025 SHALL cover MAX bcast=1, vs1 lanes 0xFFFF,5, vs2[0]=3 -> lanes 3,5; rsp_gt=0b10.
REQ-026 SHALL cover rsp_ready held 0 for 10 cycles in DONE -> outputs stable, req_ready=0, then single completion.
REQ-027 SHALL cover op=13 -> rsp_err=1, rsp_vd=0, no ALU select asserted at any cycle.
REQ-028 SHALL cover MUL 7*9 with macro -> lane 63 after 18 cycles; without macro -> rsp_err=1.
REQ-029 SHALL cover rst_n low in cycle 2 of ISSUE -> immediate reset values, no rsp_valid, next request served normally.
